// File: rtl/data_io_pkg.sv
// Shared types and constants for the ioctl download path.
// Used by the word packer and by the download front end.
package data_io_pkg;

  localparam int WADDR_W = 24;
  localparam int BADDR_W = 25;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [15:0]        data;
    logic [1:0]         be;
  } wp_entry_t;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] UIO_FILE_INFO   = 8'h56;

  function automatic logic [1:0] lane_be(input logic lane);
    return lane ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] lane_place(input logic [15:0] word, input logic lane,
                                             input logic [7:0] b);
    logic [15:0] r;
    r = word;
    if (lane) begin
      r[15:8] = b;
    end else begin
      r[7:0] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_io_wordpack_fifo.sv
// Show-ahead word FIFO; head and empty are registered from next-state so a
// push into an empty FIFO is visible on the following cycle.
module data_io_wordpack_fifo
  import data_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      push,
  input  wp_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output logic      empty_next,
  output wp_entry_t head
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  wp_entry_t        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [PTR_W:0]   count_r, count_next_s, after_pop_s;
  logic             push_ok_s, pop_ok_s, empty_r;
  wp_entry_t        head_r, head_next_s;

  assign full       = (count_r == DEPTH_C);
  assign empty      = empty_r;
  assign empty_next = (count_next_s == '0);
  assign head       = head_r;
  assign push_ok_s  = push & ~full;
  assign pop_ok_s   = pop & (count_r != '0);

  // Next-state pointers, occupancy and the entry to show next cycle.
  always_comb begin
    rd_next_s   = rd_ptr_r + (pop_ok_s ? PTR_ONE : '0);
    after_pop_s = count_r - (pop_ok_s ? CNT_ONE : '0);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (count_next_s == '0) begin
      head_next_s = '0;
    end else if (push_ok_s && (after_pop_s == '0)) begin
      head_next_s = push_entry;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk_sys) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers, count and registered head.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      head_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      empty_r  <= (count_next_s == '0);
      head_r   <= head_next_s;
    end
  end

endmodule

// File: rtl/data_io_wordpack.sv
// Packs ioctl download bytes into 16-bit words with byte enables for a
// req/ack memory port. Optional checksum output: DATA_IO_WORDPACK_CHECKSUM_EN.
module data_io_wordpack
  import data_io_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [24:0] ADDR_OFFSET = 25'h0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic        busy,
  output logic        overflow,
  output logic        done
`ifdef DATA_IO_WORDPACK_CHECKSUM_EN
  , output logic [15:0] checksum
`endif
);

  logic [BADDR_W-1:0] byte_addr_s;
  logic [WADDR_W-1:0] wa_s;
  logic               lane_s, dl_prev_r, dl_rise_s, dl_fall_s;
  logic               hold_valid_r, hold_v_eff_s, hv_next_s;
  logic [WADDR_W-1:0] hold_waddr_r, hw_next_s;
  logic [15:0]        hold_data_r, hd_next_s, merged_data_s;
  logic [1:0]         hold_be_r, hb_next_s, merged_be_s;
  logic               flush_r, flush_next_s, push_s, pop_s;
  wp_entry_t          push_entry_s, fifo_head_s;
  logic               fifo_full_s, fifo_empty_s, fifo_empty_next_s;
  logic               overflow_r, busy_r, busy_next_s, done_r, started_r;

  assign byte_addr_s  = ioctl_addr + ADDR_OFFSET;
  assign wa_s         = byte_addr_s[24:1];
  assign lane_s       = byte_addr_s[0];
  assign dl_rise_s    = ioctl_download & ~dl_prev_r;
  assign dl_fall_s    = ~ioctl_download & dl_prev_r;
  assign hold_v_eff_s = hold_valid_r & ~dl_rise_s;
  assign pop_s        = mem_ack & ~fifo_empty_s;

  // Byte merge into the hold register, push selection and flush sequencing.
  always_comb begin
    push_s        = 1'b0;
    push_entry_s  = '0;
    hv_next_s     = hold_v_eff_s;
    hw_next_s     = hold_waddr_r;
    hd_next_s     = hold_data_r;
    hb_next_s     = hold_be_r;
    flush_next_s  = flush_r;
    merged_data_s = lane_place(hold_data_r, lane_s, ioctl_dout);
    merged_be_s   = hold_be_r | lane_be(lane_s);
    if (ioctl_wr) begin
      if (hold_v_eff_s && (wa_s == hold_waddr_r)) begin
        if (merged_be_s == 2'b11) begin
          push_s       = 1'b1;
          push_entry_s = '{waddr: hold_waddr_r, data: merged_data_s, be: 2'b11};
          hv_next_s    = 1'b0;
        end else begin
          hd_next_s = merged_data_s;
          hb_next_s = merged_be_s;
        end
      end else begin
        push_s       = hold_v_eff_s;
        push_entry_s = '{waddr: hold_waddr_r, data: hold_data_r, be: hold_be_r};
        hv_next_s    = 1'b1;
        hw_next_s    = wa_s;
        hd_next_s    = lane_place(16'h0000, lane_s, ioctl_dout);
        hb_next_s    = lane_be(lane_s);
      end
    end else if (flush_r) begin
      // Flush waits for a cycle with no byte strobe, so it never competes for the push slot.
      push_s       = hold_v_eff_s;
      push_entry_s = '{waddr: hold_waddr_r, data: hold_data_r, be: hold_be_r};
      hv_next_s    = 1'b0;
      flush_next_s = 1'b0;
    end else begin
      flush_next_s = flush_r;
    end
    if (dl_fall_s) begin
      flush_next_s = 1'b1;
    end else begin
      flush_next_s = flush_next_s;
    end
    busy_next_s = ioctl_download | hv_next_s | flush_next_s | ~fifo_empty_next_s;
  end

  data_io_wordpack_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .empty_next (fifo_empty_next_s),
    .head       (fifo_head_s)
  );

  // Hold register, edge detector, flush flag and status registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev_r    <= 1'b0;
      hold_valid_r <= 1'b0;
      hold_waddr_r <= '0;
      hold_data_r  <= 16'h0000;
      hold_be_r    <= 2'b00;
      flush_r      <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      started_r    <= 1'b0;
    end else begin
      dl_prev_r    <= ioctl_download;
      hold_valid_r <= hv_next_s;
      hold_waddr_r <= hw_next_s;
      hold_data_r  <= hd_next_s;
      hold_be_r    <= hb_next_s;
      flush_r      <= flush_next_s;
      if (dl_rise_s) begin
        overflow_r <= 1'b0;
      end else if (push_s && fifo_full_s) begin
        overflow_r <= 1'b1;
      end
      busy_r    <= busy_next_s;
      done_r    <= busy_r & ~busy_next_s & started_r;
      started_r <= started_r | ioctl_download;
    end
  end

  assign mem_req  = ~fifo_empty_s;
  assign mem_addr = fifo_head_s.waddr;
  assign mem_din  = fifo_head_s.data;
  assign mem_be   = fifo_head_s.be;
  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign done     = done_r;

`ifdef DATA_IO_WORDPACK_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Running byte sum, restarted at each download rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum_r <= 16'h0000;
    end else if (dl_rise_s) begin
      checksum_r <= ioctl_wr ? {8'h00, ioctl_dout} : 16'h0000;
    end else if (ioctl_wr) begin
      checksum_r <= checksum_r + {8'h00, ioctl_dout};
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_data_io_wordpack.sv
// Scoreboard bench for data_io_wordpack: stimulus queues expected memory
// writes, an ack-driving monitor pops and compares each accepted request.
module tb_data_io_wordpack;
  import data_io_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'h0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        busy, overflow, done;
`ifdef DATA_IO_WORDPACK_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int        total = 0;
  int        bad = 0;
  int        done_cnt = 0;
  logic      ack_en = 1'b0;
  wp_entry_t sb[$];

  always #5 clk_sys = ~clk_sys;

  data_io_wordpack #(.FIFO_DEPTH(4), .ADDR_OFFSET(25'h0)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .overflow       (overflow),
    .done           (done)
`ifdef DATA_IO_WORDPACK_CHECKSUM_EN
    , .checksum     (checksum)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    sb.push_back('{waddr: a, data: d, be: be});
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic set_dl(input logic v);
    @(negedge clk_sys);
    ioctl_download = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_req) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, {31'd0, n < 300}, 32'd1);
    repeat (4) @(negedge clk_sys);
  endtask

  // Memory model: acks each request one cycle after it appears and checks it.
  initial begin
    wp_entry_t e;
    logic [15:0] m;
    forever begin
      @(negedge clk_sys);
      if (done) done_cnt++;
      if (ack_en && mem_req && !mem_ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%h din=%h be=%b required no write",
                   mem_addr, mem_din, mem_be);
        end else begin
          e = sb.pop_front();
          m = {{8{e.be[1]}}, {8{e.be[0]}}};
          if (mem_addr !== e.waddr || mem_be !== e.be || (mem_din & m) !== (e.data & m)) begin
            bad++;
            $display("FAIL mem_write: got addr=%h din=%h be=%b required addr=%h din=%h be=%b",
                     mem_addr, mem_din, mem_be, e.waddr, e.data, e.be);
          end
        end
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    int d0;
    logic [15:0] t4 [4];
    t4[0] = 16'h1110; t4[1] = 16'h1312; t4[2] = 16'h1514; t4[3] = 16'h1716;

    repeat (3) @(negedge clk_sys);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    ack_en = 1'b1;

    // Writes without a download are packed identically but never pulse done.
    push_exp(24'd20, 16'h3412, 2'b11);
    wr_byte(25'd40, 8'h12);
    wr_byte(25'd41, 8'h34);
    wait_drain("t0_drain");
    check("t0_no_done", done_cnt, 32'd0);

    // Test 1: two full words, one done pulse.
    d0 = done_cnt;
    set_dl(1'b1);
    push_exp(24'd0, 16'h2211, 2'b11);
    push_exp(24'd1, 16'h4433, 2'b11);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    wr_byte(25'd2, 8'h33);
    wr_byte(25'd3, 8'h44);
    set_dl(1'b0);
    wait_drain("t1_drain");
    check("t1_done_once", done_cnt - d0, 32'd1);
    check("t1_overflow", {31'd0, overflow}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Test 2: partial word only issued after download falls.
    set_dl(1'b1);
    push_exp(24'd0, 16'hBBAA, 2'b11);
    push_exp(24'd1, 16'h00CC, 2'b01);
    wr_byte(25'd0, 8'hAA);
    wr_byte(25'd1, 8'hBB);
    wr_byte(25'd2, 8'hCC);
    repeat (10) @(negedge clk_sys);
    check("t2_held_req", {31'd0, mem_req}, 32'd0);
    check("t2_held_sb", sb.size(), 32'd1);
    check("t2_held_busy", {31'd0, busy}, 32'd1);
    set_dl(1'b0);
    wait_drain("t2_drain");

    // Test 3: word change pushes the partial hold; flush pushes the last.
    set_dl(1'b1);
    push_exp(24'd2, 16'h5A00, 2'b10);
    push_exp(24'd4, 16'h007E, 2'b01);
    wr_byte(25'd5, 8'h5A);
    wr_byte(25'd8, 8'h7E);
    set_dl(1'b0);
    wait_drain("t3_drain");

    // Same-lane rewrite overwrites without pushing.
    set_dl(1'b1);
    push_exp(24'd3, 16'h0302, 2'b11);
    wr_byte(25'd6, 8'h01);
    wr_byte(25'd6, 8'h02);
    wr_byte(25'd7, 8'h03);
    set_dl(1'b0);
    wait_drain("t3b_drain");

    // Test 4: memory stalled; FIFO keeps words 0-3, rest overflow.
    ack_en = 1'b0;
    set_dl(1'b1);
    for (int k = 0; k < 4; k++) push_exp(24'(k), t4[k], 2'b11);
    for (int i = 0; i < 12; i++) begin
      wr_byte(25'(i), 8'h10 + 8'(i));
      if (i == 1) check("t4_latency_req", {31'd0, mem_req}, 32'd1);
      if (i == 7) check("t4_no_overflow_yet", {31'd0, overflow}, 32'd0);
      if (i == 9) check("t4_overflow_set", {31'd0, overflow}, 32'd1);
    end
    check("t4_stable_addr", {8'd0, mem_addr}, 32'd0);
    check("t4_stable_din", {16'd0, mem_din}, 32'h1110);
    ack_en = 1'b1;
    wait_drain("t4_drain");
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Test 5: reset during a pending request abandons it.
    ack_en = 1'b0;
    push_exp(24'd10, 16'h2120, 2'b11);
    wr_byte(25'd20, 8'h20);
    wr_byte(25'd21, 8'h21);
    check("t5_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("t5_rst_req", {31'd0, mem_req}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    sb.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (15) @(negedge clk_sys);
    check("t5_no_write", {31'd0, mem_req}, 32'd0);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);

`ifdef DATA_IO_WORDPACK_CHECKSUM_EN
    // Test 6: checksum over a download, cleared by the next rising edge.
    set_dl(1'b1);
    push_exp(24'd0, 16'hFFFF, 2'b11);
    push_exp(24'd1, 16'h0002, 2'b01);
    wr_byte(25'd0, 8'hFF);
    wr_byte(25'd1, 8'hFF);
    wr_byte(25'd2, 8'h02);
    check("t6_checksum", {16'd0, checksum}, 32'h0200);
    set_dl(1'b0);
    wait_drain("t6_drain");
    check("t6_checksum_kept", {16'd0, checksum}, 32'h0200);
    set_dl(1'b1);
    @(negedge clk_sys);
    check("t6_checksum_clr", {16'd0, checksum}, 32'h0000);
    set_dl(1'b0);
    repeat (5) @(negedge clk_sys);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/data_io_wordpack.md
Name: data_io_wordpack

Overview:
Downstream consumer of the ARM->FPGA file download byte stream (ioctl_*). Packs byte writes into 16-bit little-endian words with byte enables and hands them to a memory controller over a req/ack handshake. A small FIFO absorbs bursts while the memory is busy. Partial words are flushed at end of download.

Parameters:
FIFO_DEPTH, 4, word-entry FIFO depth; power of two, >=2.
ADDR_OFFSET, 25'h0, added to ioctl_addr before packing; sum truncated to 25 bits.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
ioctl_download  in  1  download active level.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address of ioctl_dout.
ioctl_dout  in  8  download byte.
mem_req  out  1  write request, level.
mem_addr  out  24  word address.
mem_din  out  16  write data; byte lane 0 = [7:0].
mem_be  out  2  byte enables.
mem_ack  in  1  one-cycle accept of current request.
busy  out  1  download active or any data not yet acked.
overflow  out  1  sticky; word dropped because FIFO full.
done  out  1  one-cycle pulse: download finished and fully written.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; hold register, flush flag, FIFO, edge detector cleared; pending request abandoned.
- Byte A = ioctl_addr+ADDR_OFFSET; word W = A[24:1]; lane L = A[0].
- Hold register {valid, waddr, data16, be2}. On ioctl_wr:
  - hold empty: load byte into lane L, be=one-hot(L).
  - hold valid, W==waddr: merge into lane L (same lane overwrites, no push).
  - hold valid, W!=waddr: push hold to FIFO; reload hold with new byte.
  - be becomes 2'b11 after merge: push in that cycle, hold becomes empty.
- At most one push per cycle.
- Falling edge of ioctl_download (registered vs previous cycle): set flush flag. Flush pushes a valid hold (partial be) in the first cycle with no other push, then clears. Flush with empty hold just clears.
- Rising edge of ioctl_download: clear overflow and hold; FIFO keeps draining.
- Push while FIFO full: entry dropped, overflow<=1, FIFO unchanged.
- Memory side: FIFO is show-ahead; mem_req = FIFO non-empty, registered.
  - Outputs stable while mem_req=1 and mem_ack=0.
  - mem_ack sampled high at edge M: pop; next entry presented in cycle M+1, or mem_req=0 if empty.
  - mem_ack while mem_req=0 is ignored.
  - Push and pop in the same cycle are both honoured.
- Latency: ioctl_wr completing a word at cycle N -> mem_req high in cycle N+1 when FIFO was empty.
- busy = ioctl_download | hold valid | flush flag | FIFO non-empty.
- done pulses once when busy falls 1->0 after a download has started; no pulse if no download since reset.
- ioctl_wr while ioctl_download=0 is accepted identically.

Optional Feature:
DATA_IO_WORDPACK_CHECKSUM_EN
- Defined: extra output checksum[15:0]. Holds the sum of every accepted byte (zero-extended, mod 2^16) since the last ioctl_download rising edge, which clears it. It updates the cycle after ioctl_wr and includes bytes later dropped by overflow.
- Undefined: port and adder absent.

Decomposition:
- Package data_io_pkg: word-address width (24); FIFO entry typedef {waddr[23:0], data[15:0], be[1:0]}; UIO command constants shared with the download front end.
- One sub-module: data_io_wordpack_fifo, a synchronous show-ahead FIFO (push, pop, full, empty, head) parameterised by FIFO_DEPTH.

Test Plan:
1. Bytes 11,22,33,44 at addr 0-3, mem_ack 1 cycle after each req -> writes (0,2211,11), (1,4433,11); done pulses once; overflow=0.
2. Bytes AA,BB,CC at addr 0-2, then download falls -> (0,BBAA,11), then (1,xxCC,01) issued only after the falling edge.
3. Byte 5A at addr 5, then byte 7E at addr 8 -> (2,5Axx,10) pushed on second byte; (4,xx7E,01) pushed at flush.
4. FIFO_DEPTH=4, mem_ack held 0, 12 bytes at addr 0-11 -> 4 entries kept, overflow=1 at 5th word; releasing ack yields exactly words 0-3.
5. reset_n low mid-download with mem_req=1 -> mem_req, busy, overflow 0 immediately; no writes after release until a new ioctl_wr.
6. With DATA_IO_WORDPACK_CHECKSUM_EN, bytes FF,FF,02 -> checksum=0x0200; new download rising edge -> checksum 0.
